// File: rtl/usb3_fifo_reader.sv
// FX3 synchronous slave-FIFO read controller: waits for FLAGA, bursts one
// fixed-length packet out of the FX3 consumer socket, flags valid words with state 6.
module usb3_fifo_reader #(
  parameter int unsigned PKT_WORDS = 256,
  parameter int unsigned READ_LAT  = 3,
  parameter int unsigned TURN      = 4,
  parameter logic [1:0]  FIFO_ADDR = 2'b11
) (
  input  logic        wrclock,
  input  logic        rst_n,
  input  logic        rd_enable,
  input  logic        USB3_FLAGA,
  input  logic [31:0] USB3_DQ,
  output logic        USB3_SLCS_N,
  output logic        USB3_SLOE_N,
  output logic        USB3_SLRD_N,
  output logic        USB3_SLWR_N,
  output logic        USB3_PKTEND_N,
  output logic [1:0]  USB3_A,
  output logic [31:0] data,
  output logic [3:0]  usb_rd_state,
  output logic [15:0] pkt_cnt,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_SEL   = 4'd1,
    S_OE    = 4'd2,
    S_ISSUE = 4'd3,
    S_DATA  = 4'd6,
    S_DONE  = 4'd7
  } state_e;

  localparam logic [8:0] PKT_W9    = 9'(PKT_WORDS);
  localparam logic [8:0] PKT_LAST  = 9'(PKT_WORDS - 1);
  localparam logic [8:0] LAT_LAST  = 9'(READ_LAT - 1);
  localparam logic [8:0] TURN_LAST = 9'(TURN - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [8:0]  issue_q, issue_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] data_q, data_d;
  logic        slcs_n_q, slcs_n_d;
  logic        sloe_n_q, sloe_n_d;
  logic        slrd_n_q, slrd_n_d;
  logic [1:0]  a_q, a_d;
  logic        busy_q, busy_d;
  logic        in_burst, in_read;

  // Phase counter is shared by ISSUE, DATA and DONE; it restarts on every state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 9'd1;
    pkt_cnt_d = pkt_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_enable && USB3_FLAGA) state_d = S_SEL;
      end
      S_SEL: begin
        cnt_d   = '0;
        state_d = S_OE;
      end
      S_OE: begin
        cnt_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == PKT_LAST) begin
          cnt_d     = '0;
          state_d   = S_DONE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with usb_rd_state.
  // SLRD_N runs off its own read count, independent of the ISSUE/DATA boundary.
  always_comb begin
    in_burst = (state_d == S_SEL) || (state_d == S_OE) ||
               (state_d == S_ISSUE) || (state_d == S_DATA);
    in_read  = (state_d == S_ISSUE) || (state_d == S_DATA);
    issue_d  = in_read ? (issue_q + {8'd0, ~slrd_n_q}) : '0;
    slrd_n_d = !(in_read && (issue_d < PKT_W9));
    slcs_n_d = !in_burst;
    sloe_n_d = !(in_burst && (state_d != S_SEL));
    a_d      = in_burst ? FIFO_ADDR : 2'b00;
    busy_d   = (state_d != S_IDLE);
    data_d   = USB3_DQ;
  end

  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      issue_q   <= '0;
      pkt_cnt_q <= '0;
      data_q    <= '0;
      slcs_n_q  <= 1'b1;
      sloe_n_q  <= 1'b1;
      slrd_n_q  <= 1'b1;
      a_q       <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      issue_q   <= issue_d;
      pkt_cnt_q <= pkt_cnt_d;
      data_q    <= data_d;
      slcs_n_q  <= slcs_n_d;
      sloe_n_q  <= sloe_n_d;
      slrd_n_q  <= slrd_n_d;
      a_q       <= a_d;
      busy_q    <= busy_d;
    end
  end

  assign USB3_SLCS_N   = slcs_n_q;
  assign USB3_SLOE_N   = sloe_n_q;
  assign USB3_SLRD_N   = slrd_n_q;
  assign USB3_SLWR_N   = 1'b1;
  assign USB3_PKTEND_N = 1'b1;
  assign USB3_A        = a_q;
  assign data          = data_q;
  assign usb_rd_state  = state_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_usb3_fifo_reader.sv
// Bench for usb3_fifo_reader: two instances (256-word and 2-word packets) driven
// by an FX3 read-socket model, checked every cycle against a burst-offset model.
module tb_usb3_fifo_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en[2], flag[2];
  logic [31:0] dq[2];
  logic [3:0]  st_o[2];
  logic        cs_o[2], oe_o[2], rd_o[2], wr_o[2], pe_o[2], busy_o[2];
  logic [1:0]  a_o[2];
  logic [31:0] data_o[2];
  logic [15:0] pkt_o[2];

  usb3_fifo_reader #(.PKT_WORDS(256), .READ_LAT(3), .TURN(4), .FIFO_ADDR(2'b11)) u_dut (
    .wrclock(clk), .rst_n(rst_n), .rd_enable(en[0]), .USB3_FLAGA(flag[0]), .USB3_DQ(dq[0]),
    .USB3_SLCS_N(cs_o[0]), .USB3_SLOE_N(oe_o[0]), .USB3_SLRD_N(rd_o[0]),
    .USB3_SLWR_N(wr_o[0]), .USB3_PKTEND_N(pe_o[0]), .USB3_A(a_o[0]), .data(data_o[0]),
    .usb_rd_state(st_o[0]), .pkt_cnt(pkt_o[0]), .busy(busy_o[0]));

  usb3_fifo_reader #(.PKT_WORDS(2), .READ_LAT(3), .TURN(4), .FIFO_ADDR(2'b11)) u_small (
    .wrclock(clk), .rst_n(rst_n), .rd_enable(en[1]), .USB3_FLAGA(flag[1]), .USB3_DQ(dq[1]),
    .USB3_SLCS_N(cs_o[1]), .USB3_SLOE_N(oe_o[1]), .USB3_SLRD_N(rd_o[1]),
    .USB3_SLWR_N(wr_o[1]), .USB3_PKTEND_N(pe_o[1]), .USB3_A(a_o[1]), .data(data_o[1]),
    .usb_rd_state(st_o[1]), .pkt_cnt(pkt_o[1]), .busy(busy_o[1]));

  function automatic int pw_of(input int i);
    return (i == 0) ? 256 : 2;
  endfunction
  localparam int RL = 3;
  localparam int TW = 4;

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hA000_0000;
  endfunction

  // FX3 socket: a read strobed in cycle t shows on DQ in cycle t+2.
  int unsigned fx_idx[2];
  logic        st_v[2];
  logic [31:0] st_w[2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_o[i]) fx_idx[i] <= 0;
      else if (!rd_o[i]) fx_idx[i] <= fx_idx[i] + 1;
      st_v[i] <= !rd_o[i] && !cs_o[i];
      st_w[i] <= base_of(i) + fx_idx[i];
      dq[i]   <= st_v[i] ? st_w[i] : $urandom;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Expected {state, SLCS_N, SLOE_N, SLRD_N, SLWR_N, PKTEND_N, A, busy} at offset k into a burst.
  function automatic logic [11:0] model_out(input bit act, input int k, input int pw);
    logic [3:0] st = 4'd0;
    logic cs = 1'b1, oe = 1'b1, rd = 1'b1, bz = 1'b0;
    logic [1:0] a = 2'b00;
    if (act) begin
      bz = 1'b1;
      if (k < 2 + RL + pw) begin cs = 1'b0; a = 2'b11; end
      if (k >= 1 && k < 2 + RL + pw) oe = 1'b0;
      if (k >= 2 && k < 2 + pw) rd = 1'b0;
      if (k == 0) st = 4'd1;
      else if (k == 1) st = 4'd2;
      else if (k < 2 + RL) st = 4'd3;
      else if (k < 2 + RL + pw) st = 4'd6;
      else st = 4'd7;
    end
    return {st, cs, oe, rd, 1'b1, 1'b1, a, bz};
  endfunction

  bit          m_act[2];
  int          m_k[2];
  logic [15:0] m_pkt[2];
  logic [31:0] prev_dq[2];
  bit          have_prev[2];
  int          dcnt[2], rcnt[2], rissue[2], gap[2], last_dcyc[2];
  bit          seen_d[2];
  logic [3:0]  prev_st[2];
  logic [31:0] last_data[2];
  int          cyc = 0;

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic [11:0] e;
    int pw;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      pw = pw_of(i);
      if (!rst_n) begin
        m_act[i] = 0; m_k[i] = 0; m_pkt[i] = '0; have_prev[i] = 0;
        continue;
      end
      e = model_out(m_act[i], m_k[i], pw);
      chk($sformatf("state%0d", i), st_o[i], e[11:8]);
      chk($sformatf("strobes%0d", i),
          {cs_o[i], oe_o[i], rd_o[i], wr_o[i], pe_o[i], a_o[i], busy_o[i]}, e[7:0]);
      chk($sformatf("pkt_cnt%0d", i), pkt_o[i], m_pkt[i]);
      if (have_prev[i]) chk($sformatf("data_reg%0d", i), data_o[i], prev_dq[i]);
      if (e[11:8] == 4'd6)
        chk($sformatf("data_word%0d", i), data_o[i], base_of(i) + 32'(m_k[i] - (2 + RL)));
      if (st_o[i] == 4'd6) begin
        dcnt[i]++;
        last_data[i] = data_o[i];
        if (prev_st[i] != 4'd6 && seen_d[i]) gap[i] = cyc - last_dcyc[i] - 1;
        last_dcyc[i] = cyc;
        seen_d[i] = 1;
      end
      if (!rd_o[i]) rcnt[i]++;
      if (!rd_o[i] && st_o[i] == 4'd3) rissue[i]++;
      prev_st[i] = st_o[i];
      if (m_act[i]) begin
        if (m_k[i] == 2 + RL + pw + TW - 1) m_act[i] = 0;
        else begin
          m_k[i]++;
          if (m_k[i] == 2 + RL + pw) m_pkt[i] = m_pkt[i] + 16'd1;
        end
      end else if (en[i] && flag[i]) begin
        m_act[i] = 1;
        m_k[i] = 0;
      end
      prev_dq[i] = dq[i];
      have_prev[i] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic wait_state(input int i, input logic [3:0] s, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      if (st_o[i] == s) return;
      tick();
    end
    chk({nm, "_timeout"}, st_o[i], s);
  endtask

  int d0, r0;

  initial begin
    rst_n = 1'b0;
    en[0] = 0; en[1] = 0; flag[0] = 0; flag[1] = 0;
    for (int i = 0; i < 2; i++) begin
      dcnt[i] = 0; rcnt[i] = 0; rissue[i] = 0; gap[i] = 0; last_dcyc[i] = 0;
      seen_d[i] = 0; prev_st[i] = 4'd0; last_data[i] = '0;
      m_act[i] = 0; m_k[i] = 0; m_pkt[i] = '0; have_prev[i] = 0; prev_dq[i] = '0;
    end
    ticks(3);
    chk("reset_state", {st_o[0], cs_o[0], oe_o[0], rd_o[0], a_o[0], busy_o[0]}, {4'd0, 3'b111, 2'b00, 1'b0});
    chk("reset_data", data_o[0], 32'd0);
    chk("reset_pkt", pkt_o[1], 16'd0);
    rst_n = 1'b1;

    // rd_enable gates burst start; then a full 256-word burst
    flag[0] = 1;
    ticks(5);
    chk("idle_when_disabled", st_o[0], 4'd0);
    en[0] = 1;
    tick();
    chk("sel_next_cycle", st_o[0], 4'd1);
    en[0] = 0;
    d0 = dcnt[0]; r0 = rcnt[0];
    wait_state(0, 4'd7, 400, "burst1_done");
    wait_state(0, 4'd0, 20, "burst1_idle");
    chk("burst1_pkt", pkt_o[0], 16'd1);
    chk("burst1_data_cycles", dcnt[0] - d0, 256);
    chk("burst1_rd_low", rcnt[0] - r0, 256);
    chk("burst1_last_word", last_data[0], 32'd255);

    // inputs dropped on the 10th DATA cycle: burst still completes, no new burst
    en[0] = 1;
    d0 = dcnt[0];
    wait_state(0, 4'd6, 20, "burst2_data");
    ticks(9);
    flag[0] = 0; en[0] = 0;
    wait_state(0, 4'd7, 400, "burst2_done");
    wait_state(0, 4'd0, 20, "burst2_idle");
    ticks(20);
    chk("burst2_stays_idle", st_o[0], 4'd0);
    chk("burst2_data_cycles", dcnt[0] - d0, 256);
    chk("burst2_pkt", pkt_o[0], 16'd2);

    // asynchronous reset mid-DATA
    flag[0] = 1; en[0] = 1;
    wait_state(0, 4'd6, 20, "burst3_data");
    en[0] = 0;
    ticks(5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", {st_o[0], cs_o[0], oe_o[0], rd_o[0], a_o[0], busy_o[0]}, {4'd0, 3'b111, 2'b00, 1'b0});
    chk("async_rst_pkt", pkt_o[0], 16'd0);
    chk("async_rst_data", data_o[0], 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    // back-to-back bursts with FLAGA held
    d0 = dcnt[0];
    en[0] = 1;
    for (int n = 0; n < 1500 && pkt_o[0] != 16'd3; n++) tick();
    chk("b2b_pkt", pkt_o[0], 16'd3);
    en[0] = 0;
    wait_state(0, 4'd0, 20, "b2b_idle");
    chk("b2b_data_cycles", dcnt[0] - d0, 768);
    chk("b2b_gap", gap[0], 10);

    // 2-word packet with a wrapping packet counter
    force u_small.pkt_cnt_q = 16'hFFFF;
    m_pkt[1] = 16'hFFFF;
    tick();
    release u_small.pkt_cnt_q;
    flag[1] = 1; en[1] = 1;
    tick();
    en[1] = 0;
    wait_state(1, 4'd7, 40, "small_done");
    wait_state(1, 4'd0, 20, "small_idle");
    chk("small_pkt_wrap", pkt_o[1], 16'd0);
    chk("small_data_cycles", dcnt[1], 2);
    chk("small_rd_low", rcnt[1], 2);
    chk("small_rd_in_issue", rissue[1], 2);
    chk("small_last_word", last_data[1], 32'hA000_0001);
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
